// File: rtl/text_console_driver_pkg.sv
// Shared constants and types for the text console driver: control bytes,
// controller states and the command set understood by the cursor block.
package text_console_pkg;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_TAB   = 8'h09;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_DEL   = 8'h7F;
    localparam logic [7:0] CH_SPACE = 8'h20;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CLEAR_ROW = 2'd1,
        CLEAR_ALL = 2'd2
    } console_state_t;

    typedef enum logic [2:0] {
        CMD_NONE    = 3'd0,
        CMD_ADVANCE = 3'd1,
        CMD_NEWLINE = 3'd2,
        CMD_BACK    = 3'd3,
        CMD_HOME    = 3'd4,
        CMD_CR      = 3'd5,
        CMD_TAB     = 3'd6
    } cursor_cmd_t;

    // DEL sits inside the printable range numerically but is an erase command.
    function automatic logic is_printable(input logic [7:0] c);
        return (c >= CH_SPACE) && (c != CH_DEL);
    endfunction

endpackage

// File: rtl/text_console_driver_if.sv
// Byte-input / character-RAM-output bundle of the text console driver.
// The driver uses the slave modport; the byte source uses master.
interface text_console_driver_if #(
    parameter int COLS   = 80,
    parameter int ROWS   = 60,
    parameter int ADDR_W = $clog2(COLS * ROWS)
);
    logic [7:0]              CHAR;
    logic                    WE;
    logic                    READY;
    logic                    DROPPED;
    logic [ADDR_W-1:0]       DISP_ADDR;
    logic [7:0]              DISP_DATA;
    logic                    DISP_WE;
    logic [$clog2(COLS)-1:0] CUR_COL;
    logic [$clog2(ROWS)-1:0] CUR_ROW;
    logic [$clog2(ROWS)-1:0] TOP_ROW;

    modport master (
        output CHAR, WE,
        input  READY, DROPPED, DISP_ADDR, DISP_DATA, DISP_WE, CUR_COL, CUR_ROW, TOP_ROW
    );

    modport slave (
        input  CHAR, WE,
        output READY, DROPPED, DISP_ADDR, DISP_DATA, DISP_WE, CUR_COL, CUR_ROW, TOP_ROW
    );
endinterface

// File: rtl/text_console_cursor.sv
// Cursor (col, logical row) and circular TOP_ROW registers, plus the
// logical-to-physical row mapping and character RAM address arithmetic.
module text_console_cursor
    import text_console_pkg::*;
#(
    parameter int COLS     = 80,
    parameter int ROWS     = 60,
    parameter int TAB_STOP = 8,
    parameter int ADDR_W   = $clog2(COLS * ROWS),
    localparam int COL_W   = $clog2(COLS),
    localparam int ROW_W   = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  cursor_cmd_t       cmd,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic [ROW_W-1:0]  top,
    output logic              at_home,
    output logic              scroll,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [ADDR_W-1:0] back_addr,
    output logic [ADDR_W-1:0] row_base
);
    localparam int          TAB_SH = $clog2(TAB_STOP);
    localparam logic [31:0] COLS_U = COLS;

    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d, top_q, top_d, top_inc;
    logic [ROW_W:0]    phys_sum;
    logic [ROW_W-1:0]  phys_row, prev_row;
    logic [ADDR_W-1:0] prev_base;
    logic [31:0]       tab_next;
    logic              last_col, last_row, newline;

    assign last_col = (col_q == COL_W'(COLS - 1));
    assign last_row = (row_q == ROW_W'(ROWS - 1));
    assign newline  = (cmd == CMD_NEWLINE) || ((cmd == CMD_ADVANCE) && last_col);
    assign scroll   = newline && last_row;
    assign at_home  = (col_q == '0) && (row_q == '0);
    assign tab_next = ((32'(col_q) >> TAB_SH) + 32'd1) << TAB_SH;
    assign top_inc  = (top_q == ROW_W'(ROWS - 1)) ? '0 : top_q + ROW_W'(1);

    // top and row are both below ROWS, so one compare-and-subtract is a full mod.
    assign phys_sum = {1'b0, top_q} + {1'b0, row_q};
    assign phys_row = (phys_sum >= (ROW_W + 1)'(ROWS)) ? ROW_W'(phys_sum - (ROW_W + 1)'(ROWS))
                                                       : ROW_W'(phys_sum);
    assign prev_row = (phys_row == '0) ? ROW_W'(ROWS - 1) : phys_row - ROW_W'(1);

    assign row_base  = ADDR_W'(phys_row) * ADDR_W'(COLS);
    assign prev_base = ADDR_W'(prev_row) * ADDR_W'(COLS);
    assign cur_addr  = row_base + ADDR_W'(col_q);
    assign back_addr = (col_q != '0) ? row_base + ADDR_W'(col_q) - ADDR_W'(1)
                                     : prev_base + ADDR_W'(COLS - 1);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        top_d = top_q;
        case (cmd)
            CMD_ADVANCE: col_d = last_col ? '0 : col_q + COL_W'(1);
            CMD_BACK: begin
                if (col_q != '0) begin
                    col_d = col_q - COL_W'(1);
                end else if (row_q != '0) begin
                    row_d = row_q - ROW_W'(1);
                    col_d = COL_W'(COLS - 1);
                end
            end
            CMD_HOME: begin
                col_d = '0;
                row_d = '0;
                top_d = '0;
            end
            CMD_CR:  col_d = '0;
            CMD_TAB: col_d = (tab_next >= COLS_U) ? COL_W'(COLS - 1) : COL_W'(tab_next);
            default: ;
        endcase
        // At the bottom row a newline rotates the screen instead of moving down.
        if (newline) begin
            if (last_row) top_d = top_inc;
            else           row_d = row_q + ROW_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
            top_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            top_q <= top_d;
        end
    end

    assign col = col_q;
    assign row = row_q;
    assign top = top_q;

endmodule

// File: rtl/text_console_driver.sv
// Byte stream to character-RAM writer for a COLS x ROWS text console with
// control characters, line wrap, hardware scroll and full/row clears.
module text_console_driver
    import text_console_pkg::*;
#(
    parameter int COLS           = 80,
    parameter int ROWS           = 60,
    parameter int TAB_STOP       = 8,
    parameter int CLEAR_ON_RESET = 1,
    parameter int ADDR_W         = $clog2(COLS * ROWS)
) (
    input  logic CLK_50MHz,
    input  logic RESET,
    text_console_driver_if.slave bus
);
    localparam int                COL_W     = $clog2(COLS);
    localparam int                ROW_W     = $clog2(ROWS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(COLS - 1);
    localparam console_state_t    RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR_ALL : IDLE;

    console_state_t    state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
    logic [7:0]        disp_data_q, disp_data_d;
    logic              disp_we_q, disp_we_d;
    logic              dropped_q, dropped_d;
    logic              ready;

    cursor_cmd_t       cmd;
    logic              at_home, scroll;
    logic [ADDR_W-1:0] cur_addr, back_addr, row_base;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row, top;

    text_console_cursor #(
        .COLS     (COLS),
        .ROWS     (ROWS),
        .TAB_STOP (TAB_STOP),
        .ADDR_W   (ADDR_W)
    ) u_cursor (
        .clk       (CLK_50MHz),
        .rst_n     (RESET),
        .cmd       (cmd),
        .col       (col),
        .row       (row),
        .top       (top),
        .at_home   (at_home),
        .scroll    (scroll),
        .cur_addr  (cur_addr),
        .back_addr (back_addr),
        .row_base  (row_base)
    );

    assign ready = (state_q == IDLE);

    // Byte decode kept apart from the state logic: scroll depends on cmd.
    always_comb begin
        cmd = CMD_NONE;
        if (ready && bus.WE) begin
            if (is_printable(bus.CHAR)) begin
                cmd = CMD_ADVANCE;
            end else begin
                case (bus.CHAR)
                    CH_CR:          cmd = CMD_CR;
                    CH_LF:          cmd = CMD_NEWLINE;
                    CH_TAB:         cmd = CMD_TAB;
                    CH_BS, CH_DEL:  cmd = at_home ? CMD_NONE : CMD_BACK;
                    CH_FF:          cmd = CMD_HOME;
                    default:        cmd = CMD_NONE;
                endcase
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        disp_we_d   = 1'b0;
        disp_addr_d = disp_addr_q;
        disp_data_d = disp_data_q;
        dropped_d   = bus.WE && !ready;
        case (state_q)
            IDLE: begin
                case (cmd)
                    CMD_ADVANCE: begin
                        disp_we_d   = 1'b1;
                        disp_addr_d = cur_addr;
                        disp_data_d = bus.CHAR;
                    end
                    CMD_BACK: begin
                        disp_we_d   = 1'b1;
                        disp_addr_d = back_addr;
                        disp_data_d = CH_SPACE;
                    end
                    CMD_HOME: begin
                        state_d = CLEAR_ALL;
                        cnt_d   = '0;
                    end
                    default: ;
                endcase
                if (scroll) begin
                    state_d = CLEAR_ROW;
                    cnt_d   = '0;
                end
            end
            // After a scroll the cursor sits on the new bottom row, which is the
            // physical row that just left the top, so row_base points at it.
            CLEAR_ROW: begin
                disp_we_d   = 1'b1;
                disp_addr_d = row_base + cnt_q;
                disp_data_d = CH_SPACE;
                if (cnt_q == LAST_COL) state_d = IDLE;
                else                   cnt_d   = cnt_q + ADDR_W'(1);
            end
            CLEAR_ALL: begin
                disp_we_d   = 1'b1;
                disp_addr_d = cnt_q;
                disp_data_d = CH_SPACE;
                if (cnt_q == LAST_ADDR) state_d = IDLE;
                else                    cnt_d   = cnt_q + ADDR_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_50MHz or negedge RESET) begin
        if (!RESET) begin
            state_q     <= RST_STATE;
            cnt_q       <= '0;
            disp_we_q   <= 1'b0;
            disp_addr_q <= '0;
            disp_data_q <= '0;
            dropped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            disp_we_q   <= disp_we_d;
            disp_addr_q <= disp_addr_d;
            disp_data_q <= disp_data_d;
            dropped_q   <= dropped_d;
        end
    end

    assign bus.READY     = ready;
    assign bus.DROPPED   = dropped_q;
    assign bus.DISP_WE   = disp_we_q;
    assign bus.DISP_ADDR = disp_addr_q;
    assign bus.DISP_DATA = disp_data_q;
    assign bus.CUR_COL   = col;
    assign bus.CUR_ROW   = row;
    assign bus.TOP_ROW   = top;

endmodule

// File: tb/tb_text_console_driver.sv
// Randomized and directed bench for text_console_driver against a slot-queue
// model of the screen: every accepted byte owns one output slot, clears follow.
module tb_text_console_driver;
    localparam int COLS   = 80;
    localparam int ROWS   = 60;
    localparam int TAB    = 8;
    localparam int N      = COLS * ROWS;
    localparam int ADDR_W = $clog2(N);

    typedef struct {
        bit v;
        int a;
        int d;
    } slot_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    int    m_col, m_row, m_top, m_busy;
    bit    m_drop;
    slot_t wq[$];

    always #10 clk = ~clk;

    text_console_driver_if #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) bus ();
    text_console_driver_if #(.COLS(10), .ROWS(3), .ADDR_W(5)) bus0 ();

    text_console_driver #(
        .COLS(COLS), .ROWS(ROWS), .TAB_STOP(TAB), .CLEAR_ON_RESET(1), .ADDR_W(ADDR_W)
    ) dut (
        .CLK_50MHz (clk),
        .RESET     (rst_n),
        .bus       (bus)
    );

    text_console_driver #(
        .COLS(10), .ROWS(3), .TAB_STOP(4), .CLEAR_ON_RESET(0), .ADDR_W(5)
    ) dut0 (
        .CLK_50MHz (clk),
        .RESET     (rst_n),
        .bus       (bus0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_addr(input int r, input int c);
        return ((m_top + r) % ROWS) * COLS + c;
    endfunction

    function automatic void push_slot(input bit v, input int a, input int d);
        slot_t s;
        s.v = v;
        s.a = a;
        s.d = d;
        wq.push_back(s);
    endfunction

    function automatic void start_clear_all();
        for (int i = 0; i < N; i++) push_slot(1'b1, i, 32);
        m_busy = N;
    endfunction

    function automatic void m_newline();
        int old_top;
        if (m_row < ROWS - 1) begin
            m_row++;
        end else begin
            old_top = m_top;
            m_top   = (m_top + 1) % ROWS;
            for (int i = 0; i < COLS; i++) push_slot(1'b1, old_top * COLS + i, 32);
            m_busy = COLS;
        end
    endfunction

    function automatic void m_byte(input int c);
        if (c >= 32 && c != 127) begin
            push_slot(1'b1, m_addr(m_row, m_col), c);
            if (m_col == COLS - 1) begin
                m_col = 0;
                m_newline();
            end else begin
                m_col++;
            end
        end else if (c == 8 || c == 127) begin
            if (m_row == 0 && m_col == 0) begin
                push_slot(1'b0, 0, 0);
            end else begin
                if (m_col > 0) m_col--;
                else begin
                    m_row--;
                    m_col = COLS - 1;
                end
                push_slot(1'b1, m_addr(m_row, m_col), 32);
            end
        end else begin
            push_slot(1'b0, 0, 0);
            if (c == 13) m_col = 0;
            else if (c == 10) m_newline();
            else if (c == 9) begin
                m_col = (m_col / TAB + 1) * TAB;
                if (m_col >= COLS) m_col = COLS - 1;
            end else if (c == 12) begin
                m_col = 0;
                m_row = 0;
                m_top = 0;
                start_clear_all();
            end
        end
    endfunction

    // Entered and left at #1 after a rising edge.
    task automatic step(input logic we, input logic [7:0] c);
        bit    rdy;
        slot_t s;
        rdy = (m_busy == 0);
        chk("ready", bus.READY, rdy);
        bus.WE   = we;
        bus.CHAR = c;
        m_drop   = we && !rdy;
        if (!rdy)    m_busy--;
        else if (we) m_byte(int'(c));
        @(posedge clk);
        #1;
        chk("dropped", bus.DROPPED, m_drop);
        if (wq.size() != 0) begin
            s = wq.pop_front();
            chk("disp_we", bus.DISP_WE, s.v);
            if (s.v) begin
                chk("disp_addr", bus.DISP_ADDR, s.a);
                chk("disp_data", bus.DISP_DATA, s.d);
            end
        end else begin
            chk("disp_we_idle", bus.DISP_WE, 0);
        end
        chk("cur_col", bus.CUR_COL, m_col);
        chk("cur_row", bus.CUR_ROW, m_row);
        chk("top_row", bus.TOP_ROW, m_top);
        bus.WE = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) step(1'b1, s[i]);
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    // Asserts reset off-edge, checks the asynchronous response, releases it.
    task automatic do_reset();
        #3 rst_n = 1'b0;
        #1;
        chk("rst_disp_we", bus.DISP_WE, 0);
        chk("rst_disp_addr", bus.DISP_ADDR, 0);
        chk("rst_disp_data", bus.DISP_DATA, 0);
        chk("rst_dropped", bus.DROPPED, 0);
        chk("rst_ready", bus.READY, 0);
        chk("rst_col", bus.CUR_COL, 0);
        chk("rst_row", bus.CUR_ROW, 0);
        chk("rst_top", bus.TOP_ROW, 0);
        chk("rst0_ready", bus0.READY, 1);
        chk("rst0_disp_we", bus0.DISP_WE, 0);
        wq.delete();
        m_col  = 0;
        m_row  = 0;
        m_top  = 0;
        m_drop = 1'b0;
        bus.WE = 1'b0;
        start_clear_all();
        @(posedge clk);
        #1;
        chk("rst_hold_we", bus.DISP_WE, 0);
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] rnd_char();
        int r;
        r = $urandom_range(0, 99);
        if (r < 55) return 8'($urandom_range(32, 126));
        if (r < 60) return 8'($urandom_range(128, 255));
        if (r < 72) return 8'h0A;
        if (r < 77) return 8'h0D;
        if (r < 82) return 8'h09;
        if (r < 88) return 8'h08;
        if (r < 93) return 8'h7F;
        return 8'($urandom_range(0, 7));
    endfunction

    initial begin
        bus.WE    = 1'b0;
        bus.CHAR  = 8'h00;
        bus0.WE   = 1'b0;
        bus0.CHAR = 8'h00;
        @(posedge clk);
        #1;
        do_reset();

        // The no-clear variant accepts a byte straight after reset.
        bus0.WE   = 1'b1;
        bus0.CHAR = 8'h51;
        step(1'b0, 8'h00);
        bus0.WE   = 1'b0;
        chk("nc_we", bus0.DISP_WE, 1);
        chk("nc_addr", bus0.DISP_ADDR, 0);
        chk("nc_data", bus0.DISP_DATA, 8'h51);
        chk("nc_col", bus0.CUR_COL, 1);

        run_idle(N + 2);

        send_str("Hello");
        chk("hello_col", bus.CUR_COL, 5);
        step(1'b1, 8'h7F);
        chk("del_col", bus.CUR_COL, 4);
        step(1'b1, 8'h0D);
        step(1'b1, 8'h7F);
        chk("del_home_we", bus.DISP_WE, 0);

        repeat (ROWS - 1) step(1'b1, 8'h0A);
        step(1'b1, 8'h0A);
        chk("scroll_top", bus.TOP_ROW, 1);
        repeat (COLS) step(1'b1, 8'h0A);
        step(1'b1, 8'h41);
        chk("after_scroll_addr", bus.DISP_ADDR, 0);

        step(1'b1, 8'h0C);
        run_idle(100);
        do_reset();
        run_idle(N + 2);

        repeat (COLS + 1) step(1'b1, 8'h78);
        chk("wrap_row", bus.CUR_ROW, 1);
        chk("wrap_col", bus.CUR_COL, 1);
        step(1'b1, 8'h0D);
        send_str("abc");
        step(1'b1, 8'h09);
        chk("tab_8", bus.CUR_COL, 8);
        step(1'b1, 8'h0D);
        repeat (COLS - 2) step(1'b1, 8'h79);
        step(1'b1, 8'h09);
        chk("tab_clamp", bus.CUR_COL, COLS - 1);

        for (int i = 0; i < 3000; i++) step($urandom_range(0, 3) != 0, rnd_char());

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
